dm_access_unit: RTL and testbench

- Pipeline-side initiator for the word-organised data memory DM (word write only, combinational read, `clk`/`res`).
- Accepts byte, halfword and word load/store requests from the MEM stage over a valid/ready handshake.
- Sequences DM accesses: read-modify-write for sub-word stores; extract and sign/zero-extend for loads.
- Returns one response per request, with an error flag for misaligned or out-of-range accesses.

---
 rtl/dm_access_unit.sv | 137 +++++++++++++
 tb/tb_dm_access_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Pipeline-side initiator for the word-organised data memory: sequences byte/half/word
// loads and stores (read-modify-write for sub-word stores) and returns one response per request.
module dm_access_unit #(
   parameter int ADDR_W   = 16,
   parameter int DM_WORDS = 3072
) (
   input  logic              clk,
   input  logic              res,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              DM_WE,
   output logic [ADDR_W-1:0] DM_addr,
   output logic [31:0]       DM_data,
   input  logic [31:0]       DM_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state;
   logic              we_q;
   logic              uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;

   function automatic logic req_bad(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
      logic [31:0] widx;
      widx = 32'(addr[ADDR_W-1:2]);
      return (size == 2'd3) ||
             (size == 2'd1 && addr[0]) ||
             (size == 2'd2 && addr[1:0] != 2'b00) ||
             (widx >= 32'(DM_WORDS));
   endfunction

   // Replace only the addressed lane; the other lanes pass through untouched.
   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = word;
      case (size)
         2'd0:    r[{off, 3'b000} +: 8]     = wdata[7:0];
         2'd1:    r[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'd0:    r = {{24{b[7] & ~uns}}, b};
         2'd1:    r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Request fields are captured once at acceptance and held for the whole access.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         we_q    <= req_we;
         uns_q   <= req_unsigned;
         size_q  <= req_size;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         merge_q    <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_bad(req_size, req_addr)) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                     state      <= RESP;
                  end else if (req_we && req_size == 2'd2) begin
                     merge_q <= req_wdata;
                     state   <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (we_q) begin
                  merge_q <= merge_lane(DM_out, wdata_q, size_q, addr_q[1:0]);
                  state   <= WRITE;
               end else begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= extract_load(DM_out, size_q, addr_q[1:0], uns_q);
                  state      <= RESP;
               end
            end
            WRITE: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'd0;
               state      <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The DM port is only driven while an access is in flight; a write is squashed under reset.
   assign req_ready = (state == IDLE);
   assign DM_WE     = (state == WRITE) && !res;
   assign DM_addr   = (state == READ || state == WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign DM_data   = (state == WRITE) ? merge_q : 32'd0;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: bench-owned DM model plus a byte-array reference of memory
// and request semantics; directed test-plan steps followed by randomized requests.
module tb_dm_access_unit;
   localparam int ADDR_W   = 16;
   localparam int DM_WORDS = 3072;

   logic              clk = 1'b0;
   logic              res;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              DM_WE;
   logic [ADDR_W-1:0] DM_addr;
   logic [31:0]       DM_data;
   logic [31:0]       DM_out;

   int n_cmp = 0;
   int n_bad = 0;

   bit [31:0] dm    [0:DM_WORDS-1];
   bit [7:0]  ref_b [0:4*DM_WORDS-1];

   logic        poke_en = 1'b0;
   int          poke_idx = 0;
   logic [31:0] poke_val = 32'd0;
   int          dm_widx;

   always #5 clk = ~clk;

   dm_access_unit #(.ADDR_W(ADDR_W), .DM_WORDS(DM_WORDS)) dut (
      .clk(clk), .res(res),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .DM_WE(DM_WE), .DM_addr(DM_addr), .DM_data(DM_data), .DM_out(DM_out)
   );

   always_comb begin
      dm_widx = int'(DM_addr[ADDR_W-1:2]);
      DM_out  = (dm_widx < DM_WORDS) ? dm[dm_widx] : 32'hDEADBEEF;
   end

   always @(posedge clk) begin
      if (DM_WE) begin
         if (dm_widx < DM_WORDS) dm[dm_widx] <= DM_data;
      end else if (poke_en) begin
         dm[poke_idx] <= poke_val;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
   endfunction

   task automatic poke(input int w, input logic [31:0] v);
      @(negedge clk);
      poke_en  = 1'b1;
      poke_idx = w;
      poke_val = v;
      for (int i = 0; i < 4; i++) ref_b[4*w+i] = v[8*i +: 8];
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Reference semantics: n-byte access at byte address a, little-endian.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata, output int lat,
                        output int wes, output logic [31:0] dmdata);
      int a;
      int n;
      logic [31:0] v;
      a = int'(addr);
      n = 1 << int'(size);
      err = (size == 2'd3) || (a % n != 0) || (a / 4 >= DM_WORDS);
      rdata = 32'd0;
      dmdata = 32'd0;
      wes = 0;
      if (err) begin
         lat = 1;
      end else if (we) begin
         for (int i = 0; i < n; i++) ref_b[a+i] = wdata[8*i +: 8];
         wes = 1;
         lat = (n == 4) ? 2 : 3;
         dmdata = ref_word(a / 4);
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_b[a+i]) << (8*i));
         if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
         rdata = v;
         lat = 2;
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata);
      logic        e_err;
      logic [31:0] e_rd;
      logic [31:0] e_dm;
      int          e_lat;
      int          e_wes;
      int          got_lat;
      int          wes;
      int          we_cyc;
      logic [31:0] we_data;
      logic [15:0] we_addr;
      logic [31:0] rd;
      logic        er;
      model(we, size, uns, addr, wdata, e_err, e_rd, e_lat, e_wes, e_dm);
      @(negedge clk);
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got_lat = 0; wes = 0; we_cyc = 0; we_data = 32'd0; we_addr = 16'd0;
      rd = 32'd0; er = 1'b0;
      for (int c = 1; c <= 6 && got_lat == 0; c++) begin
         @(negedge clk);
         if (DM_WE) begin
            wes++; we_cyc = c; we_data = DM_data; we_addr = DM_addr;
         end
         if (resp_valid) begin
            got_lat = c; rd = resp_rdata; er = resp_err;
         end
      end
      check({tag, ".lat"}, 32'(got_lat), 32'(e_lat));
      check({tag, ".err"}, 32'(er), 32'(e_err));
      check({tag, ".rdata"}, rd, e_rd);
      check({tag, ".we_cnt"}, 32'(wes), 32'(e_wes));
      if (e_wes != 0) begin
         check({tag, ".we_cyc"}, 32'(we_cyc), 32'(e_lat - 1));
         check({tag, ".we_data"}, we_data, e_dm);
         check({tag, ".we_addr"}, 32'(we_addr), 32'(addr & 16'hFFFC));
      end
   endtask

   initial begin
      logic        h_err;
      logic [31:0] h_rd [3];
      logic [31:0] h_dm;
      int          h_lat;
      int          h_wes;
      logic [15:0] h_addr [3];
      int          k;
      int          nresp;
      logic        rdy;
      int          bad_words;

      res = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.ready", 32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.rdata", resp_rdata, 32'd0);
      check("rst.err", 32'(resp_err), 32'd0);
      check("rst.dm_we", 32'(DM_WE), 32'd0);
      check("rst.dm_addr", 32'(DM_addr), 32'd0);
      check("rst.dm_data", DM_data, 32'd0);
      res = 1'b0;

      for (int w = 0; w < 64; w++) poke(w, $urandom);
      poke(8, 32'hAABBCCDD);
      poke(12, 32'h80FF7F01);

      do_req("sw10", 1'b1, 2'd2, 1'b0, 16'h0010, 32'h12345678);
      do_req("lw10", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
      do_req("sb22", 1'b1, 2'd0, 1'b0, 16'h0022, 32'hFFFFFF11);
      do_req("lw20", 1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
      do_req("lb31", 1'b0, 2'd0, 1'b0, 16'h0031, 32'h0);
      do_req("lb32", 1'b0, 2'd0, 1'b0, 16'h0032, 32'h0);
      do_req("lbu32", 1'b0, 2'd0, 1'b1, 16'h0032, 32'h0);
      do_req("lh32", 1'b0, 2'd1, 1'b0, 16'h0032, 32'h0);
      do_req("lhu32", 1'b0, 2'd1, 1'b1, 16'h0032, 32'h0);
      do_req("sh41", 1'b1, 2'd1, 1'b0, 16'h0041, 32'h0000BEEF);
      do_req("sw42", 1'b1, 2'd2, 1'b0, 16'h0042, 32'hCAFEBABE);
      do_req("lw3000", 1'b0, 2'd2, 1'b0, 16'h3000, 32'h0);
      do_req("ld_sz3", 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0);
      do_req("st_sz3", 1'b1, 2'd3, 1'b0, 16'h0010, 32'h55555555);
      do_req("sw2ffc", 1'b1, 2'd2, 1'b0, 16'h2FFC, 32'h0BADF00D);
      do_req("lh2ffe", 1'b0, 2'd1, 1'b0, 16'h2FFE, 32'h0);

      // Three loads with req_valid held high throughout.
      h_addr[0] = 16'h0010; h_addr[1] = 16'h0020; h_addr[2] = 16'h0030;
      for (int i = 0; i < 3; i++)
         model(1'b0, 2'd2, 1'b0, h_addr[i], 32'h0, h_err, h_rd[i], h_lat, h_wes, h_dm);
      k = 0; nresp = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("hs.ready", 32'(req_ready), 32'(c % 3 == 0));
         check("hs.resp_valid", 32'(resp_valid), 32'(c % 3 == 2));
         if (resp_valid && nresp < 3) begin
            check("hs.rdata", resp_rdata, h_rd[nresp]);
            nresp++;
         end
         if (k < 3) begin
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = h_addr[k];
         end else begin
            req_valid = 1'b0;
         end
         rdy = req_ready;
         @(posedge clk);
         if (rdy && req_valid) k++;
      end
      #1 req_valid = 1'b0;
      check("hs.accepted", 32'(k), 32'd3);
      check("hs.nresp", 32'(nresp), 32'd3);

      // Reset during the READ of a byte store: dropped, no write, no response.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 16'h0050; req_wdata = 32'h0000005A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmid.in_read", 32'(DM_addr), 32'h0050);
      res = 1'b1;
      @(posedge clk);
      #1;
      check("rmid.resp_valid", 32'(resp_valid), 32'd0);
      check("rmid.rdata", resp_rdata, 32'd0);
      check("rmid.err", 32'(resp_err), 32'd0);
      check("rmid.dm_we", 32'(DM_WE), 32'd0);
      check("rmid.dm_addr", 32'(DM_addr), 32'd0);
      check("rmid.dm_data", DM_data, 32'd0);
      @(negedge clk);
      res = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rmid.after_ready", 32'(req_ready), 32'd1);
         check("rmid.after_resp", 32'(resp_valid), 32'd0);
         check("rmid.after_we", 32'(DM_WE), 32'd0);
      end

      // Reset landing on the WRITE cycle must squash the write strobe.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 16'h0060;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rwr.we_before", 32'(DM_WE), 32'd1);
      res = 1'b1;
      #1 check("rwr.we_gated", 32'(DM_WE), 32'd0);
      @(negedge clk);
      res = 1'b0;
      do_req("rwr.lw60", 1'b0, 2'd2, 1'b0, 16'h0060, 32'h0);

      for (int i = 0; i < 60; i++) begin
         logic        r_we;
         logic [1:0]  r_size;
         logic        r_uns;
         logic [15:0] r_addr;
         r_we   = 1'($urandom_range(0, 1));
         r_size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_uns  = 1'($urandom_range(0, 1));
         r_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h2FF0, 16'hFFFF))
                                             : 16'($urandom_range(0, 255));
         do_req($sformatf("rnd%0d", i), r_we, r_size, r_uns, r_addr, $urandom);
      end

      bad_words = 0;
      for (int w = 0; w < DM_WORDS; w++) if (dm[w] !== ref_word(w)) bad_words++;
      check("mem.final", 32'(bad_words), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
